// File: rtl/i2c_touch_slave.sv
// I2C target emulating a capacitive touch controller.
// Register pointer is set by the host; reads come from a user-preloaded byte file.
`timescale 1ns/1ps
module i2c_touch_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h14,
   parameter int         ADDR_BYTES = 2,
   parameter int         IDX_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             scl_in,
   input  logic             sda_in,
   output logic             sda_oe,
   input  logic             reg_wr_en,
   input  logic [IDX_W-1:0] reg_wr_addr,
   input  logic [7:0]       reg_wr_data,
   output logic             host_wr_vld,
   output logic [15:0]      host_wr_addr,
   output logic [7:0]       host_wr_data,
   output logic             busy
);

   typedef enum logic [3:0] {
      IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK,
      WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
   } state_t;

   state_t      state;
   logic [2:0]  scl_sr, sda_sr;
   logic [3:0]  cnt;
   logic [7:0]  shreg;
   logic        rw;
   logic        ab;
   logic        wr_pend;
   logic [15:0] ptr;
   logic [7:0]  file_q [2**IDX_W];

   logic scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] rd_byte;

   // [1:0] synchronise, [2] is the edge-detect history
   assign scl_rise  = scl_sr[1] & ~scl_sr[2];
   assign scl_fall  = ~scl_sr[1] & scl_sr[2];
   assign start_det = scl_sr[1] & scl_sr[2] & ~sda_sr[1] & sda_sr[2];
   assign stop_det  = scl_sr[1] & scl_sr[2] & sda_sr[1] & ~sda_sr[2];
   assign rd_byte   = file_q[ptr[IDX_W-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sr <= 3'b111;
         sda_sr <= 3'b111;
      end else begin
         scl_sr <= {scl_sr[1:0], scl_in};
         sda_sr <= {sda_sr[1:0], sda_in};
      end
   end

   // User port is written last so it wins a same-index collision
   always_ff @(posedge clk) begin
      if (wr_pend && !rst)
         file_q[ptr[IDX_W-1:0]] <= shreg;
      if (reg_wr_en)
         file_q[reg_wr_addr] <= reg_wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         shreg        <= 8'h00;
         rw           <= 1'b0;
         ab           <= 1'b0;
         wr_pend      <= 1'b0;
         ptr          <= 16'h0000;
         sda_oe       <= 1'b0;
         busy         <= 1'b0;
         host_wr_vld  <= 1'b0;
         host_wr_addr <= 16'h0000;
         host_wr_data <= 8'h00;
      end else begin
         host_wr_vld <= 1'b0;
         wr_pend     <= 1'b0;
         if (wr_pend) begin
            host_wr_vld  <= 1'b1;
            host_wr_addr <= ptr;
            host_wr_data <= shreg;
            ptr          <= ptr + 16'd1;
         end
         if (stop_det) begin
            state  <= IDLE;
            busy   <= 1'b0;
            sda_oe <= 1'b0;
         end else if (start_det) begin
            state  <= DEV_ADDR;
            cnt    <= 4'd0;
            sda_oe <= 1'b0;
         end else begin
            unique case (state)
               DEV_ADDR: begin
                  if (scl_rise) begin
                     shreg <= {shreg[6:0], sda_sr[1]};
                     cnt   <= cnt + 4'd1;
                  end else if (scl_fall && cnt == 4'd8) begin
                     if (shreg[7:1] == SLAVE_ADDR) begin
                        state  <= DEV_ACK;
                        sda_oe <= 1'b1;
                        busy   <= 1'b1;
                        rw     <= shreg[0];
                     end else begin
                        state <= IGNORE;
                        busy  <= 1'b0;
                     end
                  end
               end
               DEV_ACK: begin
                  if (scl_fall) begin
                     cnt <= 4'd0;
                     if (rw) begin
                        state  <= RD_DATA;
                        shreg  <= rd_byte;
                        sda_oe <= ~rd_byte[7];
                     end else begin
                        state  <= REG_ADDR;
                        sda_oe <= 1'b0;
                        ab     <= 1'b0;
                     end
                  end
               end
               REG_ADDR: begin
                  if (scl_rise) begin
                     shreg <= {shreg[6:0], sda_sr[1]};
                     cnt   <= cnt + 4'd1;
                  end else if (scl_fall && cnt == 4'd8) begin
                     state  <= REG_ACK;
                     sda_oe <= 1'b1;
                     if (ADDR_BYTES == 2 && !ab) begin
                        ptr[15:8] <= shreg;
                     end else begin
                        ptr[7:0] <= shreg;
                        if (ADDR_BYTES == 1)
                           ptr[15:8] <= 8'h00;
                     end
                  end
               end
               REG_ACK: begin
                  if (scl_fall) begin
                     sda_oe <= 1'b0;
                     cnt    <= 4'd0;
                     if (ADDR_BYTES == 1 || ab) begin
                        state <= WR_DATA;
                     end else begin
                        state <= REG_ADDR;
                        ab    <= 1'b1;
                     end
                  end
               end
               WR_DATA: begin
                  if (scl_rise) begin
                     shreg <= {shreg[6:0], sda_sr[1]};
                     cnt   <= cnt + 4'd1;
                     if (cnt == 4'd7)
                        wr_pend <= 1'b1;
                  end else if (scl_fall && cnt == 4'd8) begin
                     state  <= WR_ACK;
                     sda_oe <= 1'b1;
                  end
               end
               WR_ACK: begin
                  if (scl_fall) begin
                     state  <= WR_DATA;
                     sda_oe <= 1'b0;
                     cnt    <= 4'd0;
                  end
               end
               RD_DATA: begin
                  if (scl_rise) begin
                     cnt <= cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (cnt == 4'd8) begin
                        state  <= RD_ACK;
                        sda_oe <= 1'b0;
                     end else if (cnt != 4'd0) begin
                        shreg  <= {shreg[6:0], 1'b0};
                        sda_oe <= ~shreg[6];
                     end
                  end
               end
               // Pointer advances for every byte served, acked or not
               RD_ACK: begin
                  if (scl_rise) begin
                     ptr <= ptr + 16'd1;
                     if (sda_sr[1]) begin
                        state <= IGNORE;
                        busy  <= 1'b0;
                     end else begin
                        cnt <= 4'd9;
                     end
                  end else if (scl_fall && cnt == 4'd9) begin
                     state  <= RD_DATA;
                     cnt    <= 4'd0;
                     shreg  <= rd_byte;
                     sda_oe <= ~rd_byte[7];
                  end
               end
               IDLE: ;
               IGNORE: ;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_touch_slave.sv
// Bench for i2c_touch_slave: bit-banged I2C host against a
// register-file/pointer model of the touch controller.
`timescale 1ns/1ps
module tb_i2c_touch_slave;

   localparam time Q = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scl_m = 1'b1;
   logic        sda_m = 1'b1;
   logic        scl_in, sda_in, sda_oe;
   logic        reg_wr_en = 1'b0;
   logic [7:0]  reg_wr_addr = 8'h00;
   logic [7:0]  reg_wr_data = 8'h00;
   logic        host_wr_vld;
   logic [15:0] host_wr_addr;
   logic [7:0]  host_wr_data;
   logic        busy;

   always #5 clk = ~clk;

   assign scl_in = scl_m;
   assign sda_in = sda_m & ~sda_oe;

   i2c_touch_slave dut (
      .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
      .sda_oe(sda_oe), .reg_wr_en(reg_wr_en),
      .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
      .host_wr_vld(host_wr_vld), .host_wr_addr(host_wr_addr),
      .host_wr_data(host_wr_data), .busy(busy)
   );

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wev_t;

   int          vecs = 0;
   int          errs = 0;
   logic [7:0]  mem [256];
   logic [15:0] mptr = 16'h0000;
   wev_t        got_q [$];
   wev_t        exp_q [$];
   logic [7:0]  wbuf [$];
   logic        watch = 1'b0;
   logic        oe_seen = 1'b0;
   logic        busy_seen = 1'b0;

   always @(negedge clk) begin
      if (host_wr_vld)
         got_q.push_back(wev_t'{host_wr_addr, host_wr_data});
      if (watch) begin
         if (sda_oe) oe_seen = 1'b1;
         if (busy) busy_seen = 1'b1;
      end
   end

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      reg_wr_en = 1'b1;
      reg_wr_addr = a;
      reg_wr_data = d;
      @(negedge clk);
      reg_wr_en = 1'b0;
      mem[a] = d;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b0; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b1; #Q;
   endtask

   task automatic bit_io(input logic b, output logic s);
      sda_m = b; #Q;
      scl_m = 1'b1; #Q;
      s = sda_in; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_io(b[i], s);
      bit_io(1'b1, s);
      ack = ~s;
   endtask

   task automatic rd_byte(input logic nack, output logic [7:0] v);
      logic s;
      v = 8'h00;
      for (int i = 0; i < 8; i++) begin
         bit_io(1'b1, s);
         v = {v[6:0], s};
      end
      bit_io(nack, s);
   endtask

   // Host write of wbuf at register ra, compared against the model
   task automatic xfer_write(input logic [15:0] ra);
      logic ack;
      i2c_start();
      wr_byte(8'h28, ack);
      vecs++;
      if (ack !== 1'b1) begin
         errs++; $display("FAIL wr_dev_ack got %b want 1", ack);
      end
      wr_byte(ra[15:8], ack);
      wr_byte(ra[7:0], ack);
      vecs++;
      if (ack !== 1'b1) begin
         errs++; $display("FAIL wr_reg_ack got %b want 1", ack);
      end
      mptr = ra;
      foreach (wbuf[i]) begin
         wr_byte(wbuf[i], ack);
         vecs++;
         if (ack !== 1'b1) begin
            errs++; $display("FAIL wr_data_ack byte %0d got %b want 1", i, ack);
         end
         exp_q.push_back(wev_t'{mptr, wbuf[i]});
         mem[mptr[7:0]] = wbuf[i];
         mptr++;
      end
      i2c_stop();
      vecs++;
      if (got_q.size() != exp_q.size()) begin
         errs++;
         $display("FAIL wr_events count got %0d want %0d",
                  got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            vecs++;
            if (got_q[i] !== exp_q[i]) begin
               errs++;
               $display("FAIL wr_event %0d got %h/%h want %h/%h", i,
                        got_q[i].a, got_q[i].d, exp_q[i].a, exp_q[i].d);
            end
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   // Host read of n bytes, optionally setting the pointer first
   task automatic xfer_read(input logic [15:0] ra, input int n,
                            input logic set_addr);
      logic ack;
      logic [7:0] v;
      i2c_start();
      if (set_addr) begin
         wr_byte(8'h28, ack);
         wr_byte(ra[15:8], ack);
         wr_byte(ra[7:0], ack);
         vecs++;
         if (ack !== 1'b1) begin
            errs++; $display("FAIL rd_setaddr_ack got %b want 1", ack);
         end
         mptr = ra;
         i2c_start();
      end
      wr_byte(8'h29, ack);
      vecs++;
      if (ack !== 1'b1 || busy !== 1'b1) begin
         errs++; $display("FAIL rd_dev_ack ack %b busy %b want 1 1", ack, busy);
      end
      for (int i = 0; i < n; i++) begin
         rd_byte(i == n - 1, v);
         vecs++;
         if (v !== mem[mptr[7:0]]) begin
            errs++;
            $display("FAIL rd_data ptr %h got %h want %h", mptr, v, mem[mptr[7:0]]);
         end
         mptr++;
      end
      i2c_stop();
      vecs++;
      if (busy !== 1'b0) begin
         errs++; $display("FAIL rd_busy_after_stop got %b want 0", busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vecs++;
      if ({sda_oe, host_wr_vld, busy} !== 3'b000 ||
          host_wr_addr !== 16'h0000 || host_wr_data !== 8'h00) begin
         errs++;
         $display("FAIL reset_outputs got oe%b vld%b busy%b %h %h want 0",
                  sda_oe, host_wr_vld, busy, host_wr_addr, host_wr_data);
      end
      rst = 1'b0;
      for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
   endtask

   task automatic test_ptr_read();
      preload(8'h4E, 8'h80);
      xfer_read(16'h814E, 1, 1'b1);
   endtask

   task automatic test_host_write();
      wbuf = '{8'h12, 8'h34};
      xfer_write(16'h8150);
      xfer_read(16'h8150, 2, 1'b1);
   endtask

   task automatic test_addr_mismatch();
      logic ack;
      watch = 1'b1;
      oe_seen = 1'b0;
      busy_seen = 1'b0;
      i2c_start();
      wr_byte(8'h2A, ack);
      vecs++;
      if (ack !== 1'b0) begin
         errs++; $display("FAIL mismatch_ack got %b want 0", ack);
      end
      wr_byte(8'h81, ack);
      wr_byte(8'h4E, ack);
      i2c_stop();
      watch = 1'b0;
      vecs++;
      if (oe_seen !== 1'b0 || busy_seen !== 1'b0 || got_q.size() != 0) begin
         errs++;
         $display("FAIL mismatch_quiet got oe %b busy %b wr %0d want 0 0 0",
                  oe_seen, busy_seen, got_q.size());
      end
      got_q.delete();
   endtask

   task automatic test_wrap_read();
      preload(8'hFE, 8'hA1);
      preload(8'hFF, 8'hA2);
      preload(8'h00, 8'hA3);
      preload(8'h01, 8'hA4);
      xfer_read(16'h81FE, 4, 1'b1);
      vecs++;
      if (mptr !== 16'h8202) begin
         errs++; $display("FAIL model_ptr got %h want 8202", mptr);
      end
      xfer_read(16'h0000, 1, 1'b0);
   endtask

   task automatic test_reset_mid_read();
      logic ack, s;
      i2c_start();
      wr_byte(8'h28, ack);
      wr_byte(8'h81, ack);
      wr_byte(8'h4E, ack);
      i2c_start();
      wr_byte(8'h29, ack);
      for (int i = 0; i < 3; i++) bit_io(1'b1, s);
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #(Q/2);
      vecs++;
      if (sda_oe !== 1'b1) begin
         errs++; $display("FAIL mid_read_drive got %b want 1", sda_oe);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      vecs++;
      if (sda_oe !== 1'b0 || busy !== 1'b0 || host_wr_vld !== 1'b0) begin
         errs++;
         $display("FAIL rst_mid_read got oe %b busy %b vld %b want 0 0 0",
                  sda_oe, busy, host_wr_vld);
      end
      @(negedge clk);
      rst = 1'b0;
      #Q;
      scl_m = 1'b0; #Q;
      i2c_stop();
      mptr = 16'h0000;
      xfer_read(16'h814E, 1, 1'b1);
   endtask

   task automatic test_partial_write();
      logic ack, s;
      i2c_start();
      wr_byte(8'h28, ack);
      wr_byte(8'h81, ack);
      wr_byte(8'h60, ack);
      vecs++;
      if (ack !== 1'b1) begin
         errs++; $display("FAIL partial_addr_ack got %b want 1", ack);
      end
      for (int i = 0; i < 4; i++) bit_io(~mem[8'h60][7-i], s);
      i2c_stop();
      vecs++;
      if (got_q.size() != 0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL partial_write got wr %0d busy %b want 0 0",
                  got_q.size(), busy);
      end
      got_q.delete();
      xfer_read(16'h8160, 1, 1'b1);
   endtask

   task automatic test_random();
      logic [15:0] ra;
      int n;
      for (int it = 0; it < 6; it++) begin
         ra = 16'($urandom);
         n = $urandom_range(1, 4);
         wbuf.delete();
         for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom));
         xfer_write(ra);
         preload(8'($urandom), 8'($urandom));
         xfer_read(ra, n, 1'b1);
      end
   endtask

   task automatic test_back_to_back();
      logic ack;
      logic [7:0] v;
      mptr = 16'h4020;
      i2c_start();
      wr_byte(8'h28, ack);
      wr_byte(8'h40, ack);
      wr_byte(8'h20, ack);
      wr_byte(8'h5A, ack);
      exp_q.push_back(wev_t'{mptr, 8'h5A});
      mem[mptr[7:0]] = 8'h5A;
      mptr++;
      i2c_start();
      wr_byte(8'h29, ack);
      rd_byte(1'b1, v);
      vecs++;
      if (v !== mem[mptr[7:0]]) begin
         errs++; $display("FAIL b2b_read got %h want %h", v, mem[mptr[7:0]]);
      end
      i2c_stop();
      vecs++;
      if (got_q.size() != 1 || (got_q.size() == 1 && got_q[0] !== exp_q[0])) begin
         errs++; $display("FAIL b2b_write got %0d events want 1 (%h)",
                          got_q.size(), exp_q[0]);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_ptr_read();
      test_host_write();
      test_addr_mismatch();
      test_wrap_read();
      test_reset_mid_read();
      test_partial_write();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
